// File: rtl/conv5x5_filt.sv
// 5x5 programmable convolution for one 8-bit component of the HDMI filter path.
// Row taps arrive vertically aligned; each row builds its horizontal window, products and row sum.

module conv5x5_row #(
    parameter int COEF_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tap,
    input  logic [4:0][COEF_W-1:0]        coef,
    output logic signed [COEF_W+11:0]     row_sum
);
    localparam int PW = 9 + COEF_W;
    localparam int RW = PW + 3;

    logic [4:0][7:0]    win;
    logic [4:0][PW-1:0] prod_d;
    logic [4:0][PW-1:0] prod_q;
    logic signed [RW-1:0] sum_d;

    // pixels are unsigned, so a zero MSB makes them safe signed operands
    always_comb begin
        for (int c = 0; c < 5; c++) begin
            prod_d[c] = PW'($signed({1'b0, win[c]})) * PW'($signed(coef[c]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int c = 0; c < 5; c++) begin
            sum_d = sum_d + RW'($signed(prod_q[c]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win     <= '0;
            prod_q  <= '0;
            row_sum <= '0;
        end else begin
            win     <= {win[3:0], tap};
            prod_q  <= prod_d;
            row_sum <= sum_d;
        end
    end
endmodule

module conv5x5_filt #(
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pa,
    input  logic [7:0]        pb,
    input  logic [7:0]        pc,
    input  logic [7:0]        pd,
    input  logic [7:0]        pe,
    input  logic              stat_in,
    input  logic              coef_wr,
    input  logic [4:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_din,
    output logic [7:0]        pixel_o,
    output logic              stat_o
);
    localparam int PW     = 9 + COEF_W;
    localparam int RW     = PW + 3;
    localparam int TW     = RW + 3;
    localparam int STAGES = 6;

    logic [24:0][COEF_W-1:0] coef;
    logic [4:0][7:0]         taps;
    logic [4:0][RW-1:0]      row_sum;
    logic signed [TW-1:0]    total_d;
    logic signed [TW-1:0]    scaled;
    logic [7:0]              pixel_d;
    logic [STAGES-1:0]       stat_pipe;

    assign taps = {pe, pd, pc, pb, pa};

    // reset leaves an identity kernel: centre tap scaled to cancel the normalising shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef     <= '0;
            coef[12] <= COEF_W'(1 << SHIFT);
        end else if (coef_wr && (coef_addr < 5'd25)) begin
            coef[coef_addr] <= coef_din;
        end
    end

    for (genvar r = 0; r < 5; r++) begin : g_row
        conv5x5_row #(.COEF_W(COEF_W)) u_row (
            .clk     (clk),
            .rst     (rst),
            .tap     (taps[r]),
            .coef    (coef[5*r+4:5*r]),
            .row_sum (row_sum[r])
        );
    end

    always_comb begin
        total_d = '0;
        for (int r = 0; r < 5; r++) begin
            total_d = total_d + TW'($signed(row_sum[r]));
        end
        scaled = total_d >>> SHIFT;
        if (scaled[TW-1])
            pixel_d = 8'd0;
        else if (scaled > $signed(TW'(255)))
            pixel_d = 8'd255;
        else
            pixel_d = scaled[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_o   <= '0;
            stat_pipe <= '0;
        end else begin
            pixel_o   <= pixel_d;
            stat_pipe <= {stat_pipe[STAGES-2:0], stat_in};
        end
    end

    assign stat_o = stat_pipe[STAGES-1];
endmodule

// File: tb/tb_conv5x5_filt.sv
// Directed/randomised bench for conv5x5_filt against a cycle-indexed arithmetic model.
module tb_conv5x5_filt;
    localparam int COEF_W = 8;
    localparam int SHIFT  = 4;
    localparam int HN     = 4096;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] pa, pb, pc, pd, pe;
    logic stat_in, coef_wr;
    logic [4:0] coef_addr;
    logic [COEF_W-1:0] coef_din;
    logic [7:0] pixel_o;
    logic stat_o;

    always #5 clk = ~clk;

    conv5x5_filt #(.COEF_W(COEF_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
        .stat_in(stat_in), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_din(coef_din), .pixel_o(pixel_o), .stat_o(stat_o)
    );

    int hist_tap [HN][5];
    bit hist_stat [HN];
    int coef_hist [HN][25];
    int mcoef [25];
    int cyc_n, valid_from;
    int n_pass, n_fail, n_tot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // output in cycle n sees taps from cycle n-4-c at column c and coefs written by cycle n-4
    function automatic int ref_pix(input int n);
        int sum, k, v;
        sum = 0;
        if (n - 4 < valid_from || n - 4 < 0) return 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                k = n - 4 - c;
                if (k >= valid_from) sum += hist_tap[k][r] * coef_hist[n-4][5*r+c];
            end
        v = sum >>> SHIFT;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int ref_stat(input int n);
        if (n - 6 < valid_from || n - 6 < 0) return 0;
        return int'(hist_stat[n-6]);
    endfunction

    task automatic cyc();
        #1;
        if (!rst) begin
            chk("pix_rst", pixel_o, 0);
            chk("stat_rst", stat_o, 0);
        end else begin
            chk("pix", pixel_o, ref_pix(cyc_n));
            chk("stat", stat_o, ref_stat(cyc_n));
        end
        hist_tap[cyc_n] = '{int'(pa), int'(pb), int'(pc), int'(pd), int'(pe)};
        hist_stat[cyc_n] = stat_in;
        if (!rst) begin
            for (int i = 0; i < 25; i++) mcoef[i] = 0;
            mcoef[12] = 1 << SHIFT;
            valid_from = cyc_n + 1;
        end else if (coef_wr && coef_addr < 25) begin
            mcoef[coef_addr] = int'($signed(coef_din));
        end
        coef_hist[cyc_n] = mcoef;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic rnd_taps();
        pa = 8'($urandom); pb = 8'($urandom); pc = 8'($urandom);
        pd = 8'($urandom); pe = 8'($urandom);
    endtask

    task automatic set_taps(input int v);
        pa = 8'(v); pb = 8'(v); pc = 8'(v); pd = 8'(v); pe = 8'(v);
    endtask

    task automatic wcoef(input int a, input int v);
        coef_wr = 1'b1; coef_addr = 5'(a); coef_din = 8'(v);
        cyc();
        coef_wr = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 25; i++) wcoef(i, v);
    endtask

    int pcq [12];
    int seen_cnt, seen_at;

    initial begin
        rst = 1'b1; stat_in = 0; coef_wr = 0; coef_addr = 0; coef_din = 0;
        set_taps(0);
        cyc_n = 0; valid_from = 0; n_pass = 0; n_fail = 0; n_tot = 0;
        for (int i = 0; i < 25; i++) mcoef[i] = 0;
        mcoef[12] = 1 << SHIFT;
        #2 rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;

        // identity pass-through on centre row
        for (int i = 0; i < 256; i++) begin
            rnd_taps(); pc = 8'(i); stat_in = 0;
            if (i >= 6) chk("ident", pixel_o, i - 6);
            cyc();
        end

        set_all(1); set_taps(100);
        repeat (12) cyc();
        chk("box", pixel_o, 156);

        set_all(127); set_taps(255);
        repeat (12) cyc();
        chk("clamp_hi", pixel_o, 255);

        set_all(-1); set_taps(10);
        repeat (12) cyc();
        chk("clamp_lo", pixel_o, 0);

        // only the newest pa sample contributes; out-of-range writes must be ignored
        set_all(0); wcoef(0, 16);
        for (int i = 0; i < 40; i++) begin
            rnd_taps(); pa = 8'(3 * i + 1);
            coef_wr = (i == 20 || i == 21);
            coef_addr = (i == 20) ? 5'd25 : 5'd31;
            coef_din = 8'h55;
            if (i >= 4) chk("tap0", pixel_o, 3 * (i - 4) + 1);
            cyc();
        end
        coef_wr = 0;

        seen_cnt = 0; seen_at = -1;
        for (int i = 0; i < 20; i++) begin
            stat_in = (i == 5);
            if (stat_o) begin seen_cnt++; seen_at = i; end
            cyc();
        end
        stat_in = 0;
        chk("stat_cnt", seen_cnt, 1);
        chk("stat_at", seen_at, 11);

        for (int i = 0; i < 25; i++) begin
            rnd_taps();
            wcoef(i, int'($urandom_range(40)) - 20);
        end
        for (int i = 0; i < 150; i++) begin
            rnd_taps(); stat_in = 1'($urandom);
            coef_wr = ($urandom_range(9) == 0);
            coef_addr = 5'($urandom); coef_din = 8'($urandom_range(30));
            cyc();
        end
        coef_wr = 0;

        // async reset in the middle of a running blur
        set_all(1); set_taps(100); stat_in = 1;
        repeat (12) cyc();
        chk("box2", pixel_o, 156);
        chk("stat_hi", stat_o, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_pix", pixel_o, 0);
        chk("mid_rst_stat", stat_o, 0);
        cyc();
        rst = 1'b1; stat_in = 0;
        for (int i = 0; i < 12; i++) begin
            pc = 8'($urandom); pcq[i] = int'(pc);
            if (i >= 6) chk("post_rst", pixel_o, pcq[i-6]);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
